// File: rtl/bg_redraw_controller.sv
// Background redraw sequencer: sweeps every pixel of the background ROM in raster
// order and forwards colour-aligned plot strobes to the VGA adapter.
module bg_redraw_controller #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 240
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] game_state,
  input  logic       redraw_req,
  output logic [3:0] bg_state,
  output logic [8:0] bg_x,
  output logic [7:0] bg_y,
  input  logic [2:0] bg_color,
  output logic       plot,
  output logic [8:0] plot_x,
  output logic [7:0] plot_y,
  output logic [2:0] plot_color,
  output logic       busy,
  output logic       done
);

  // state  | meaning
  // IDLE   | waiting for a pending redraw, a game_state change or redraw_req
  // SWEEP  | issuing one pixel address per cycle in raster order
  // FLUSH  | last ROM read in flight; last plot goes out this cycle
  // DONE   | one-cycle completion pulse; restarts at once if a redraw is pending
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_FLUSH, S_DONE} state_t;

  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  state_t     state_q, state_d;
  logic [3:0] bg_state_q, bg_state_d;
  logic [8:0] bg_x_q, bg_x_d;
  logic [7:0] bg_y_q, bg_y_d;
  logic       pend_q, pend_d;
  logic       plot_q, plot_d;
  logic [8:0] plot_x_q, plot_x_d;
  logic [7:0] plot_y_q, plot_y_d;
  logic       change;
  logic       start;

  always_comb begin
    state_d    = state_q;
    bg_state_d = bg_state_q;
    bg_x_d     = bg_x_q;
    bg_y_d     = bg_y_q;
    pend_d     = pend_q;
    start      = 1'b0;
    change     = (game_state != bg_state_q) || redraw_req;

    case (state_q)
      S_IDLE: begin
        if (pend_q || change) start = 1'b1;
      end
      S_SWEEP: begin
        if (change) pend_d = 1'b1;
        if (bg_x_q == X_LAST) begin
          if (bg_y_q == Y_LAST) begin
            state_d = S_FLUSH;
          end else begin
            bg_x_d = 9'd0;
            bg_y_d = bg_y_q + 8'd1;
          end
        end else begin
          bg_x_d = bg_x_q + 9'd1;
        end
      end
      S_FLUSH: begin
        if (change) pend_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (pend_q) begin
          start = 1'b1;
        end else begin
          // a change seen here is caught again by IDLE, but record it anyway
          if (change) pend_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // pend is cleared only when a sweep actually starts
    if (start) begin
      state_d    = S_SWEEP;
      bg_state_d = game_state;
      bg_x_d     = 9'd0;
      bg_y_d     = 8'd0;
      pend_d     = 1'b0;
    end

    plot_d   = (state_q == S_SWEEP);
    plot_x_d = bg_x_q;
    plot_y_d = bg_y_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bg_state_q <= 4'd0;
      bg_x_q     <= 9'd0;
      bg_y_q     <= 8'd0;
      pend_q     <= 1'b1;
      plot_q     <= 1'b0;
      plot_x_q   <= 9'd0;
      plot_y_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      bg_state_q <= bg_state_d;
      bg_x_q     <= bg_x_d;
      bg_y_q     <= bg_y_d;
      pend_q     <= pend_d;
      plot_q     <= plot_d;
      plot_x_q   <= plot_x_d;
      plot_y_q   <= plot_y_d;
    end
  end

  assign bg_state   = bg_state_q;
  assign bg_x       = bg_x_q;
  assign bg_y       = bg_y_q;
  assign plot       = plot_q;
  assign plot_x     = plot_x_q;
  assign plot_y     = plot_y_q;
  assign plot_color = bg_color;
  assign busy       = (state_q == S_SWEEP) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_bg_redraw_controller.sv
// Scoreboard bench for bg_redraw_controller on a reduced 16x6 frame with a
// 1-cycle ROM model whose colour is (x + y + state) mod 8.
module tb_bg_redraw_controller;

  localparam int W = 16;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] game_state;
  logic       redraw_req;
  logic [3:0] bg_state;
  logic [8:0] bg_x;
  logic [7:0] bg_y;
  logic [2:0] bg_color = 3'd0;
  logic       plot;
  logic [8:0] plot_x;
  logic [7:0] plot_y;
  logic [2:0] plot_color;
  logic       busy;
  logic       done;

  bg_redraw_controller #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .game_state(game_state), .redraw_req(redraw_req),
    .bg_state(bg_state), .bg_x(bg_x), .bg_y(bg_y), .bg_color(bg_color),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // background ROM: one cycle of read latency
  always @(posedge clock) bg_color <= 3'((int'(bg_x) + int'(bg_y) + int'(bg_state)) % 8);

  typedef struct packed {
    logic [3:0] st;
    logic [8:0] x;
    logic [7:0] y;
  } pix_t;

  pix_t       exp_q[$];
  logic [3:0] done_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_sweep(input logic [3:0] st);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back('{st: st, x: 9'(x), y: 8'(y)});
    done_q.push_back(st);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < budget);
    check("done_seen", int'(done), 1);
  endtask

  // monitor: pops the scoreboard on every plot strobe and every done pulse
  initial begin
    int   cyc = 0;
    int   start_cyc = 0;
    logic busy_prev = 1'b0;
    pix_t e;
    logic [3:0] ds;
    forever begin
      @(negedge clock);
      cyc++;
      if (busy && !busy_prev) start_cyc = cyc;
      busy_prev = busy;
      if (plot) begin
        if (exp_q.size() == 0) begin
          check("plot_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("plot_x", int'(plot_x), int'(e.x));
          check("plot_y", int'(plot_y), int'(e.y));
          check("plot_color", int'(plot_color), (int'(e.x) + int'(e.y) + int'(e.st)) % 8);
        end
      end
      if (int'(bg_x) > W - 1 || int'(bg_y) > H - 1) check("addr_range", 1, 0);
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          ds = done_q.pop_front();
          check("done_state", int'(bg_state), int'(ds));
          check("done_latency", cyc - start_cyc + 1, N + 2);
        end
      end
    end
  end

  initial begin
    int d0;
    int n;
    reset = 1'b1;
    game_state = 4'd0;
    redraw_req = 1'b0;
    repeat (3) tick();
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bg_x", int'(bg_x), 0);
    check("rst_bg_y", int'(bg_y), 0);
    check("rst_plot_xy", int'(plot_x) + int'(plot_y), 0);

    // pending redraw of state 0 straight out of reset
    push_sweep(4'd0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", int'(busy), 1);
    check("post_rst_state", int'(bg_state), 0);
    wait_done(N + 10);
    repeat (3) tick();
    check("idle_busy", int'(busy), 0);

    // idle state changes 0->1->2
    game_state = 4'd1;
    push_sweep(4'd1);
    tick();
    check("chg1_state", int'(bg_state), 1);
    wait_done(N + 10);
    repeat (3) tick();
    game_state = 4'd2;
    push_sweep(4'd2);
    tick();
    check("chg2_state", int'(bg_state), 2);
    check("chg2_busy", int'(busy), 1);
    wait_done(N + 10);
    repeat (3) tick();

    // mid-sweep changes 3->5->7 collapse into one follow-up sweep of 7
    game_state = 4'd3;
    push_sweep(4'd3);
    d0 = done_cnt;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(busy && bg_x == 9'd10 && bg_y == 8'd3) && n < N + 10);
    check("mid_reached", int'(bg_x == 9'd10 && bg_y == 8'd3), 1);
    game_state = 4'd5;
    push_sweep(4'd7);
    repeat (4) tick();
    game_state = 4'd7;
    check("mid_old_state", int'(bg_state), 3);
    wait_done(N + 10);
    check("mid_done_state", int'(bg_state), 3);
    tick();
    check("mid_restart_busy", int'(busy), 1);
    check("mid_restart_state", int'(bg_state), 7);
    wait_done(N + 10);
    repeat (5) tick();
    check("mid_done_count", done_cnt - d0, 2);
    check("mid_idle_busy", int'(busy), 0);

    // redraw_req in idle, then twice during the sweep -> one extra sweep
    d0 = done_cnt;
    redraw_req = 1'b1;
    push_sweep(4'd7);
    tick();
    redraw_req = 1'b0;
    check("req_busy", int'(busy), 1);
    repeat (20) tick();
    redraw_req = 1'b1;
    tick();
    redraw_req = 1'b0;
    repeat (20) tick();
    redraw_req = 1'b1;
    tick();
    redraw_req = 1'b0;
    push_sweep(4'd7);
    wait_done(N + 10);
    wait_done(N + 10);
    repeat (5) tick();
    check("req_done_count", done_cnt - d0, 2);
    check("req_idle_busy", int'(busy), 0);

    // reset in the middle of a sweep
    game_state = 4'd0;
    push_sweep(4'd0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(plot && plot_x == 9'd5 && plot_y == 8'd2) && n < N + 10);
    check("rst_mid_reached", int'(plot && plot_x == 9'd5 && plot_y == 8'd2), 1);
    reset = 1'b1;
    tick();
    check("rst_mid_plot", int'(plot), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_bg_x", int'(bg_x), 0);
    exp_q.delete();
    done_q.delete();
    reset = 1'b0;
    push_sweep(4'd0);
    d0 = done_cnt;
    wait_done(N + 10);
    repeat (5) tick();
    check("rst_mid_done_count", done_cnt - d0, 1);

    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
